// File: rtl/key_event.sv
// Per-channel button event decoder: press/release pulses plus long-press and auto-repeat timing.
// The release and repeat outputs are named release_pulse/repeat_pulse because release and repeat are SystemVerilog keywords.
module key_event #(
  parameter int WIDTH      = 1,
  parameter int LONG_CYC   = 50_000_000,
  parameter int REPEAT_CYC = 10_000_000
) (
  input  logic             clk,
  input  logic             sys_rst_n,
  input  logic [WIDTH-1:0] btn,
  output logic [WIDTH-1:0] press,
  output logic [WIDTH-1:0] release_pulse,
  output logic [WIDTH-1:0] long_press,
  output logic [WIDTH-1:0] repeat_pulse,
  output logic [WIDTH-1:0] held
);

  localparam int MAX_CYC = (LONG_CYC > REPEAT_CYC) ? LONG_CYC : REPEAT_CYC;
  localparam int CW      = $clog2(MAX_CYC + 1);
  localparam logic [CW-1:0] LONG_T = CW'(LONG_CYC - 1);
  localparam logic [CW-1:0] REP_T  = CW'(REPEAT_CYC - 1);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PRESSED = 2'd1,
    ST_REPEAT  = 2'd2
  } state_t;

  for (genvar g = 0; g < WIDTH; g++) begin : g_ch
    state_t        state;
    logic [CW-1:0] cnt;
    logic          press_q;
    logic          release_q;
    logic          long_q;
    logic          repeat_q;
    logic          held_q;

    always_ff @(posedge clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
        state     <= ST_IDLE;
        cnt       <= '0;
        press_q   <= 1'b0;
        release_q <= 1'b0;
        long_q    <= 1'b0;
        repeat_q  <= 1'b0;
        held_q    <= 1'b0;
      end else begin
        press_q   <= 1'b0;
        release_q <= 1'b0;
        long_q    <= 1'b0;
        repeat_q  <= 1'b0;
        case (state)
          ST_IDLE: begin
            cnt <= '0;
            if (btn[g]) begin
              state   <= ST_PRESSED;
              press_q <= 1'b1;
              held_q  <= 1'b1;
            end else begin
              held_q <= 1'b0;
            end
          end
          // Release is tested first so it wins over a coinciding terminal count.
          ST_PRESSED: begin
            if (!btn[g]) begin
              state     <= ST_IDLE;
              cnt       <= '0;
              release_q <= 1'b1;
              held_q    <= 1'b0;
            end else if (cnt == LONG_T) begin
              state  <= ST_REPEAT;
              cnt    <= '0;
              long_q <= 1'b1;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          ST_REPEAT: begin
            if (!btn[g]) begin
              state     <= ST_IDLE;
              cnt       <= '0;
              release_q <= 1'b1;
              held_q    <= 1'b0;
            end else if (cnt == REP_T) begin
              cnt      <= '0;
              repeat_q <= 1'b1;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          default: begin
            state  <= ST_IDLE;
            cnt    <= '0;
            held_q <= 1'b0;
          end
        endcase
      end
    end

    assign press[g]         = press_q;
    assign release_pulse[g] = release_q;
    assign long_press[g]    = long_q;
    assign repeat_pulse[g]  = repeat_q;
    assign held[g]          = held_q;
  end

endmodule

// File: tb/tb_key_event.sv
// Bench for key_event: run-length reference model checked every cycle, plus directed timing scenarios.
module tb_key_event;
  localparam int W = 2;
  localparam int L = 8;
  localparam int R = 4;

  logic         clk = 1'b0;
  logic         sys_rst_n = 1'b0;
  logic [W-1:0] btn = '0;
  logic [W-1:0] press, release_pulse, long_press, repeat_pulse, held;

  int tests = 0;
  int fails = 0;

  // Model state: number of consecutive edges each button has been sampled high.
  int           run [W];
  logic [W-1:0] e_press = '0, e_rel = '0, e_long = '0, e_rep = '0, e_held = '0;

  key_event #(.WIDTH(W), .LONG_CYC(L), .REPEAT_CYC(R)) dut (
    .clk           (clk),
    .sys_rst_n     (sys_rst_n),
    .btn           (btn),
    .press         (press),
    .release_pulse (release_pulse),
    .long_press    (long_press),
    .repeat_pulse  (repeat_pulse),
    .held          (held)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial for (int c = 0; c < W; c++) run[c] = 0;

  always @(negedge sys_rst_n) begin
    for (int c = 0; c < W; c++) run[c] = 0;
    e_press = '0; e_rel = '0; e_long = '0; e_rep = '0; e_held = '0;
  end

  always @(posedge clk) begin
    if (sys_rst_n) begin
      for (int c = 0; c < W; c++) begin
        if (btn[c]) begin
          run[c]++;
          e_press[c] = (run[c] == 1);
          e_long[c]  = (run[c] == L + 1);
          e_rep[c]   = (run[c] > L + 1) && (((run[c] - L - 1) % R) == 0);
          e_rel[c]   = 1'b0;
          e_held[c]  = 1'b1;
        end else begin
          e_rel[c]   = (run[c] > 0);
          run[c]     = 0;
          e_press[c] = 1'b0;
          e_long[c]  = 1'b0;
          e_rep[c]   = 1'b0;
          e_held[c]  = 1'b0;
        end
      end
    end
  end

  always @(negedge clk) begin
    chk("model_press", press, e_press);
    chk("model_release", release_pulse, e_rel);
    chk("model_long", long_press, e_long);
    chk("model_repeat", repeat_pulse, e_rep);
    chk("model_held", held, e_held);
  end

  initial begin
    int hc;
    logic lseen;

    #12;
    chk("reset_outputs", {press, release_pulse, long_press, repeat_pulse, held}, 0);
    @(posedge clk); #1 sys_rst_n = 1'b1;
    tick(); tick();

    // Short hold of 5 cycles
    btn = 2'b01; tick();
    chk("short_press", press, 2'b01);
    hc = held[0] ? 1 : 0;
    lseen = long_press[0];
    for (int i = 1; i <= 5; i++) begin
      btn = (i < 5) ? 2'b01 : 2'b00;
      tick();
      if (held[0]) hc++;
      lseen |= long_press[0];
      if (i == 5) chk("short_release", release_pulse, 2'b01);
    end
    chk("short_held_cycles", hc, 5);
    chk("short_no_long", lseen, 1'b0);
    tick(); tick();

    // 20-cycle hold: long press and repeats
    btn = 2'b01; tick();
    chk("long_press_edge", press, 2'b01);
    for (int i = 1; i <= 20; i++) begin
      btn = (i < 20) ? 2'b01 : 2'b00;
      tick();
      if (i == 8) chk("long_at_8", long_press, 2'b01);
      if (i == 12 || i == 16) chk("repeat_at_12_16", repeat_pulse, 2'b01);
      if (i == 20) chk("long_release_20", release_pulse, 2'b01);
    end
    tick(); tick();

    // Release on terminal count wins
    btn = 2'b10; tick();
    for (int i = 1; i <= 8; i++) begin
      btn = (i < 8) ? 2'b10 : 2'b00;
      tick();
      if (i == 8) begin
        chk("tc_release", release_pulse, 2'b10);
        chk("tc_no_long", long_press, 2'b00);
      end
    end
    tick(); tick();

    // Independent channels
    btn = 2'b11; tick();
    chk("dual_press", press, 2'b11);
    for (int i = 1; i <= 10; i++) begin
      btn = {1'(i < 3), 1'(i < 10)};
      tick();
      if (i == 3) chk("dual_release1", release_pulse, 2'b10);
      if (i == 8) chk("dual_long0", long_press, 2'b01);
      if (i == 10) chk("dual_release0", release_pulse, 2'b01);
    end
    tick(); tick();

    // Asynchronous reset mid-hold
    btn = 2'b01; tick();
    for (int i = 1; i <= 10; i++) tick();
    #1 sys_rst_n = 1'b0;
    #1 chk("async_reset_outputs", {press, release_pulse, long_press, repeat_pulse, held}, 0);
    #1 sys_rst_n = 1'b1;
    tick();
    chk("post_reset_press", press, 2'b01);
    chk("post_reset_no_release", release_pulse, 2'b00);
    for (int i = 1; i <= 8; i++) begin
      tick();
      if (i == 8) chk("post_reset_long", long_press, 2'b01);
    end
    btn = 2'b00; tick(); tick();

    // One-cycle blip
    btn = 2'b01; tick();
    chk("blip_press", press, 2'b01);
    chk("blip_held", held, 2'b01);
    btn = 2'b00; tick();
    chk("blip_release", release_pulse, 2'b01);
    chk("blip_press_low", press, 2'b00);
    chk("blip_held_low", held, 2'b00);
    tick();

    // Randomized long-run traffic with occasional resets
    for (int n = 0; n < 3000; n++) begin
      for (int c = 0; c < W; c++)
        if ($urandom_range(0, 15) == 0) btn[c] = ~btn[c];
      if ($urandom_range(0, 399) == 0) begin
        #1 sys_rst_n = 1'b0;
        #1 sys_rst_n = 1'b1;
      end
      tick();
    end

    btn = 2'b00;
    tick(); tick();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/key_event.md
KEY_EVENT -- requirements
Module: key_event

Interface
REQ-001 SHALL have parameter WIDTH, default 1: number of independent button channels.
REQ-002 SHALL have parameter LONG_CYC, default 50_000_000: cycles from press pulse to long_press pulse; legal range >= 2.
REQ-003 SHALL have parameter REPEAT_CYC, default 10_000_000: cycles between repeat pulses; legal range >= 1.
REQ-004 SHALL have port clk, input, 1: clock; all state updates on rising edge.
REQ-005 SHALL have port sys_rst_n, input, 1: reset, asynchronous, active-low.
REQ-006 SHALL have port btn, input, WIDTH: debounced button levels, synchronous to clk, 1 = pressed.
REQ-007 SHALL have port press, output, WIDTH: one-cycle pulse per channel on press detection.
REQ-008 SHALL have port release, output, WIDTH: one-cycle pulse per channel on release detection.
REQ-009 SHALL have port long_press, output, WIDTH: one-cycle pulse when a press is held LONG_CYC cycles.
REQ-010 SHALL have port repeat, output, WIDTH: one-cycle pulse every REPEAT_CYC cycles after long_press while held.
REQ-011 SHALL have port held, output, WIDTH: level, 1 while channel is in PRESSED or REPEAT.

Function
REQ-012 SHALL implement, per channel, an independent FSM with states IDLE, PRESSED, REPEAT and a counter of width $clog2(max(LONG_CYC, REPEAT_CYC)+1).
REQ-013 SHALL register all outputs; no combinational path from btn to any output.
REQ-014 IDLE, btn=1 at edge: SHALL go to PRESSED, cnt=0, press=1 for the following cycle.
REQ-015 IDLE, btn=0: SHALL stay IDLE, cnt=0, all pulses 0.
REQ-016 PRESSED, btn=1, cnt != LONG_CYC-1: SHALL increment cnt.
REQ-017 PRESSED, btn=1, cnt == LONG_CYC-1: SHALL go to REPEAT, cnt=0, long_press=1 for one cycle (long_press exactly LONG_CYC cycles after press).
REQ-018 REPEAT, btn=1, cnt == REPEAT_CYC-1: SHALL set cnt=0 and repeat=1 for one cycle; otherwise increment cnt.
REQ-019 PRESSED or REPEAT, btn=0 at edge: SHALL go to IDLE, cnt=0, release=1 for one cycle.
REQ-020 Release coinciding with terminal count: release SHALL win; no long_press/repeat emitted that cycle.
REQ-021 Counter SHALL never wrap past its terminal value; repeat pulses SHALL continue indefinitely while held.
REQ-022 press and release on the same channel SHALL never assert in the same cycle; channels SHALL not interact.
REQ-023 held SHALL equal 1 in the cycle press is high and 0 in the cycle release is high.
REQ-024 A btn high for exactly one cycle SHALL yield press, then release on the next cycle.

Reset
REQ-025 sys_rst_n=0 SHALL immediately force all channels to IDLE, cnt=0, and press, release, long_press, repeat, held to 0, regardless of clk.
REQ-026 Reset mid-hold SHALL abort without a release pulse; if btn still 1 after deassertion, the first edge SHALL emit press.

Verification (WIDTH=2, LONG_CYC=8, REPEAT_CYC=4)
REQ-027 btn[0] 0->1 sampled at edge k, held 5 cycles, then 0 -> press[0] after edge k, release[0] after edge k+5, no long_press, held[0] high 5 cycles.
REQ-028 btn[0] held 20 cycles from edge k -> long_press[0] after edge k+8, repeat[0] after edges k+12, k+16; release[0] after edge k+20.
REQ-029 btn[1] drops at edge k+8 (terminal count) -> release[1] only, long_press[1] stays 0.
REQ-030 btn[0] and btn[1] rise at same edge, btn[1] released 3 cycles later -> independent press pulses same cycle; btn[0] timing unaffected.
REQ-031 sys_rst_n pulsed low mid-cycle at k+10 while held -> outputs 0 asynchronously, no release; after deassertion with btn=1, press on next edge and long_press 8 cycles later.
REQ-032 btn[0] one-cycle high -> press[0] then release[0] in consecutive cycles, held[0] high exactly 1 cycle.
